// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetches 32-bit words from a 16x32 instruction memory and issues 16-bit halves,
// sharing the memory port with a loader that may write words only at word boundaries.
module imem_fetch_ctrl #(
  parameter int FAIR_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ld_req,
  input  logic [3:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ack,
  output logic [31:0] mem_pc,
  output logic        mem_write,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_pc
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, LOAD} state_t;
  state_t state_q, state_d;
  logic [31:0] fpc_q, fpc_d, wbuf_q, wbuf_d, ppc_q, ppc_d;
  logic pend_q, pend_d, fair_q, fair_d;
  logic [31:0] tgt;
  logic fair_ok, unused_pc0;
  assign tgt = {redirect_pc[31:1], 1'b0};
  assign unused_pc0 = redirect_pc[0];
  assign fair_ok = (FAIR_EN == 0) || !fair_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fpc_q   <= '0;
      wbuf_q  <= '0;
      ppc_q   <= '0;
      pend_q  <= 1'b0;
      fair_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      wbuf_q  <= wbuf_d;
      ppc_q   <= ppc_d;
      pend_q  <= pend_d;
      fair_q  <= fair_d;
    end
  end
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    wbuf_d  = wbuf_q;
    ppc_d   = ppc_q;
    pend_d  = pend_q;
    fair_d  = fair_q;
    unique case (state_q)
      // With no fetch demand there is nothing to be fair to, so the loader is always granted.
      IDLE: if (ld_req && (fair_ok || !fetch_en)) begin
        state_d = LOAD;
        if (redirect) begin
          pend_d = 1'b1;
          ppc_d  = tgt;
        end
      end else if (redirect) begin
        fpc_d   = tgt;
        state_d = FETCH;
      end else if (fetch_en) state_d = FETCH;
      FETCH: if (redirect) fpc_d = tgt;
      else begin
        wbuf_d  = mem_rdata;
        fair_d  = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: if (redirect) begin
        fpc_d   = tgt;
        state_d = FETCH;
      end else if (fetch_en && !stall) begin
        fpc_d   = fpc_q + 32'd2;
        state_d = !fpc_q[1] ? ISSUE : (ld_req && fair_ok) ? LOAD : FETCH;
      end
      LOAD: begin
        fair_d = 1'b1;
        pend_d = 1'b0;
        if (redirect || pend_q) begin
          fpc_d   = redirect ? tgt : ppc_q;
          state_d = FETCH;
        end else state_d = fetch_en ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign instr_valid = state_q == ISSUE;
  assign instr       = instr_valid ? (fpc_q[1] ? wbuf_q[15:0] : wbuf_q[31:16]) : 16'h0;
  assign instr_pc    = instr_valid ? fpc_q : 32'h0;
  assign mem_write   = state_q == LOAD;
  assign ld_ack      = mem_write;
  assign mem_din     = mem_write ? ld_data : 32'h0;
  assign mem_pc      = mem_write ? {26'b0, ld_addr, 2'b00}
                     : state_q == FETCH ? {fpc_q[31:2], 2'b00} : 32'h0;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed scenarios for imem_fetch_ctrl against a 16x32 negedge-write memory model.
module tb_imem_fetch_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic fetch_en = 1'b0, stall = 1'b0, redirect = 1'b0, ld_req = 1'b0;
  logic [31:0] redirect_pc = '0, ld_data = '0;
  logic [3:0] ld_addr = '0;
  logic ld_ack, mem_write, instr_valid;
  logic [31:0] mem_pc, mem_din, mem_rdata, instr_pc;
  logic [15:0] instr;
  logic [31:0] mem [16];
  logic mem_init = 1'b0;
  int tests = 0, fails = 0;

  imem_fetch_ctrl #(.FAIR_EN(1)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .ld_req(ld_req),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack), .mem_pc(mem_pc),
    .mem_write(mem_write), .mem_din(mem_din), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_pc[5:2]];

  function automatic logic [31:0] init_word(int i);
    return i == 0 ? 32'h200A88C9 : {16'hA000 + 16'(i), 16'hB000 + 16'(i)};
  endfunction

  always @(negedge clk)
    if (mem_init) for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    else if (mem_write) mem[mem_pc[5:2]] <= mem_din;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_init = 1'b1;
    fetch_en = 0; stall = 0; redirect = 0; redirect_pc = 0; ld_req = 0; ld_addr = 0; ld_data = 0;
    tick(); tick();
    mem_init = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_init = 1'b1;
    tick(); tick();
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    tests++; if (instr !== 16'h0) begin fails++; $display("FAIL rst_instr got=%h exp=0000", instr); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    tests++; if (mem_pc !== 32'h0) begin fails++; $display("FAIL rst_mem_pc got=%h exp=0", mem_pc); end
    tests++; if ({mem_write, ld_ack} !== 2'b00) begin fails++; $display("FAIL rst_wr_ack got=%b exp=00", {mem_write, ld_ack}); end
    tests++; if (mem_din !== 32'h0) begin fails++; $display("FAIL rst_mem_din got=%h exp=0", mem_din); end
    do_reset();
    tick();
    tests++; if (instr_valid !== 1'b0 || mem_pc !== 32'h0) begin fails++; $display("FAIL idle_hold valid=%b mem_pc=%h exp 0/0", instr_valid, mem_pc); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    fetch_en = 1'b1;
    tick();
    tests++; if (mem_pc !== 32'h0 || instr_valid !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL basic_fetch0 mem_pc=%h valid=%b wr=%b exp 0/0/0", mem_pc, instr_valid, mem_write); end
    tick();
    tests++; if (instr !== 16'h200A || instr_pc !== 32'h0 || instr_valid !== 1'b1) begin fails++; $display("FAIL basic_issue0 instr=%h pc=%h valid=%b exp 200A/0/1", instr, instr_pc, instr_valid); end
    tick();
    tests++; if (instr !== 16'h88C9 || instr_pc !== 32'h2) begin fails++; $display("FAIL basic_issue2 instr=%h pc=%h exp 88C9/2", instr, instr_pc); end
    tick();
    tests++; if (mem_pc !== 32'h4 || instr_valid !== 1'b0) begin fails++; $display("FAIL basic_fetch1 mem_pc=%h valid=%b exp 4/0", mem_pc, instr_valid); end
    tick();
    tests++; if (instr !== 16'hA001 || instr_pc !== 32'h4) begin fails++; $display("FAIL basic_issue4 instr=%h pc=%h exp A001/4", instr, instr_pc); end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_en = 1'b1;
    tick(); tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (instr !== 16'h88C9 || instr_pc !== 32'h2 || instr_valid !== 1'b1 || mem_write !== 1'b0 || mem_pc !== 32'h0) begin
        fails++; $display("FAIL stall_hold%0d instr=%h pc=%h valid=%b wr=%b mem_pc=%h exp 88C9/2/1/0/0", k, instr, instr_pc, instr_valid, mem_write, mem_pc);
      end
    end
    stall = 1'b0;
    tick();
    tests++; if (mem_pc !== 32'h4) begin fails++; $display("FAIL stall_resume_fetch mem_pc=%h exp 4", mem_pc); end
    tick();
    tests++; if (instr_pc !== 32'h4 || instr !== 16'hA001) begin fails++; $display("FAIL stall_resume_issue pc=%h instr=%h exp 4/A001", instr_pc, instr); end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h31;
    tick();
    tests++; if (mem_pc !== 32'h30 || instr_valid !== 1'b0) begin fails++; $display("FAIL redir_fetch mem_pc=%h valid=%b exp 30/0", mem_pc, instr_valid); end
    redirect = 1'b0;
    tick();
    tests++; if (instr_pc !== 32'h30 || instr !== 16'hA00C) begin fails++; $display("FAIL redir_issue pc=%h instr=%h exp 30/A00C", instr_pc, instr); end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3E;
    tick();
    tests++; if (mem_pc !== 32'h3C || instr_valid !== 1'b0) begin fails++; $display("FAIL redir_over_stall mem_pc=%h valid=%b exp 3C/0", mem_pc, instr_valid); end
    stall = 1'b0; redirect = 1'b0;
    tick();
    tests++; if (instr_pc !== 32'h3E || instr !== 16'hB00F) begin fails++; $display("FAIL wrap_issue3e pc=%h instr=%h exp 3E/B00F", instr_pc, instr); end
    tick();
    tests++; if (mem_pc !== 32'h40) begin fails++; $display("FAIL wrap_fetch mem_pc=%h exp 40", mem_pc); end
    tick();
    tests++; if (instr_pc !== 32'h40 || instr !== 16'h200A) begin fails++; $display("FAIL wrap_issue40 pc=%h instr=%h exp 40/200A", instr_pc, instr); end
  endtask

  task automatic test_loader();
    do_reset();
    fetch_en = 1'b1;
    tick(); tick();
    ld_req = 1'b1; ld_addr = 4'd5; ld_data = 32'hDEADBEEF;
    tick();
    tests++; if (instr_pc !== 32'h2 || instr_valid !== 1'b1 || mem_write !== 1'b0 || ld_ack !== 1'b0) begin fails++; $display("FAIL ld_no_split pc=%h valid=%b wr=%b ack=%b exp 2/1/0/0", instr_pc, instr_valid, mem_write, ld_ack); end
    fetch_en = 1'b0;
    tick(); tick();
    tests++; if (instr_pc !== 32'h2 || mem_write !== 1'b0 || instr_valid !== 1'b1) begin fails++; $display("FAIL ld_no_grant_idle_fetch pc=%h wr=%b valid=%b exp 2/0/1", instr_pc, mem_write, instr_valid); end
    fetch_en = 1'b1;
    tick();
    tests++; if (mem_write !== 1'b1 || ld_ack !== 1'b1 || mem_pc !== 32'h14 || mem_din !== 32'hDEADBEEF || instr_valid !== 1'b0) begin
      fails++; $display("FAIL ld_load wr=%b ack=%b mem_pc=%h din=%h valid=%b exp 1/1/14/DEADBEEF/0", mem_write, ld_ack, mem_pc, mem_din, instr_valid);
    end
    ld_req = 1'b0;
    tick();
    tests++; if (mem_write !== 1'b0 || ld_ack !== 1'b0 || mem_pc !== 32'h4 || mem_din !== 32'h0) begin fails++; $display("FAIL ld_refetch wr=%b ack=%b mem_pc=%h din=%h exp 0/0/4/0", mem_write, ld_ack, mem_pc, mem_din); end
    tests++; if (mem[5] !== 32'hDEADBEEF) begin fails++; $display("FAIL ld_mem_word got=%h exp DEADBEEF", mem[5]); end
    tick();
    tests++; if (instr_pc !== 32'h4 || instr !== 16'hA001) begin fails++; $display("FAIL ld_after_issue pc=%h instr=%h exp 4/A001", instr_pc, instr); end
  endtask

  task automatic test_fairness();
    int acks = 0;
    do_reset();
    fetch_en = 1'b1; ld_req = 1'b1; ld_addr = 4'd3; ld_data = 32'h0BADF00D;
    for (int k = 1; k <= 16; k++) begin
      tick();
      acks += int'(ld_ack);
      tests++; if (ld_ack !== ((k - 1) % 4 == 0)) begin fails++; $display("FAIL fair_seq%0d ack=%b exp %b", k, ld_ack, (k - 1) % 4 == 0); end
    end
    tests++; if (instr_pc !== 32'hE || acks != 4) begin fails++; $display("FAIL fair_progress pc=%h acks=%0d exp E/4", instr_pc, acks); end
    ld_req = 1'b0;
  endtask

  task automatic test_load_redirect();
    do_reset();
    fetch_en = 1'b1; ld_req = 1'b1; ld_addr = 4'd2; ld_data = 32'h12345678;
    tick();
    ld_req = 1'b0; redirect = 1'b1; redirect_pc = 32'h21;
    #1;
    tests++; if (ld_ack !== 1'b1 || mem_write !== 1'b1) begin fails++; $display("FAIL ldredir_ack ack=%b wr=%b exp 1/1", ld_ack, mem_write); end
    tick();
    tests++; if (mem_pc !== 32'h20 || ld_ack !== 1'b0) begin fails++; $display("FAIL ldredir_fetch mem_pc=%h ack=%b exp 20/0", mem_pc, ld_ack); end
    redirect = 1'b0;
    tick();
    tests++; if (instr_pc !== 32'h20 || instr !== 16'hA008) begin fails++; $display("FAIL ldredir_issue pc=%h instr=%h exp 20/A008", instr_pc, instr); end
    do_reset();
    ld_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h19;
    tick();
    tests++; if (ld_ack !== 1'b1 || mem_pc !== 32'h0) begin fails++; $display("FAIL idle_ld_wins ack=%b mem_pc=%h exp 1/0", ld_ack, mem_pc); end
    ld_req = 1'b0; redirect = 1'b0;
    tick();
    tests++; if (mem_pc !== 32'h18 || mem_write !== 1'b0) begin fails++; $display("FAIL pending_fetch mem_pc=%h wr=%b exp 18/0", mem_pc, mem_write); end
    tick();
    tests++; if (instr_pc !== 32'h18 || instr !== 16'hA006) begin fails++; $display("FAIL pending_issue pc=%h instr=%h exp 18/A006", instr_pc, instr); end
  endtask

  task automatic test_reset_in_load();
    do_reset();
    ld_req = 1'b1; ld_addr = 4'd9; ld_data = 32'hCAFE0001;
    tick();
    tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL rstld_pre wr=%b exp 1", mem_write); end
    reset = 1'b1;
    #1;
    tests++; if (mem_write !== 1'b0 || ld_ack !== 1'b0 || mem_din !== 32'h0) begin fails++; $display("FAIL rstld_async wr=%b ack=%b din=%h exp 0/0/0", mem_write, ld_ack, mem_din); end
    ld_req = 1'b0;
    tick();
    tests++; if (mem[9] !== init_word(9)) begin fails++; $display("FAIL rstld_no_write got=%h exp %h", mem[9], init_word(9)); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect();
    test_loader();
    test_fairness();
    test_load_redirect();
    test_reset_in_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
